// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: BOOT/RUN/HALTED sequencing with prioritised redirects.
// Latency: a redirect reaches pc one clock after it is accepted; misaligned pulses one clock after the request.
// Backpressure: while imem_ready=0 the pc holds and the best redirect seen so far waits in a one-entry pending slot.
module pc_fetch_unit #(
    parameter int                   PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = 'h10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_src,
    input  logic [PC_WIDTH-1:0] pc_target,
    input  logic                jalr,
    input  logic [PC_WIDTH-1:0] jalr_base,
    input  logic [PC_WIDTH-1:0] jalr_offset,
    input  logic                trap,
    input  logic                halt_req,
    input  logic                resume,
    input  logic                imem_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                pc_valid,
    output logic                misaligned,
    output logic                halted
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Redirect priority codes; NONE doubles as "pending slot empty".
    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_JALR = 2'd2;
    localparam logic [1:0] PRI_TRAP = 2'd3;

    logic [1:0]          state;
    logic [1:0]          pend_pri;
    logic [PC_WIDTH-1:0] pend_tgt;

    logic [PC_WIDTH-1:0] br_tgt;
    logic [PC_WIDTH-1:0] jalr_sum;
    logic [PC_WIDTH-1:0] jalr_tgt;

    logic [1:0]          req_pri;
    logic [PC_WIDTH-1:0] req_tgt;
    logic                req_bad;

    logic                take_new;
    logic [1:0]          eff_pri;
    logic [PC_WIDTH-1:0] eff_tgt;

    assign pc_plus4 = pc + PC_WIDTH'(4);
    assign pc_valid = (state == ST_RUN);
    assign halted   = (state == ST_HALT);

    assign br_tgt   = pc + pc_target;
    assign jalr_sum = jalr_base + jalr_offset;
    assign jalr_tgt = {jalr_sum[PC_WIDTH-1:1], 1'b0};

    // Pick this cycle's winning request; a misaligned winner is dropped, not replaced by a lower one.
    always_comb begin
        req_pri = PRI_NONE;
        req_tgt = pc_plus4;
        req_bad = 1'b0;
        if (trap) begin
            req_pri = PRI_TRAP;
            req_tgt = TRAP_VECTOR;
        end else if (jalr) begin
            if (jalr_tgt[1]) begin
                req_bad = 1'b1;
            end else begin
                req_pri = PRI_JALR;
                req_tgt = jalr_tgt;
            end
        end else if (pc_src) begin
            if (br_tgt[1:0] != 2'b00) begin
                req_bad = 1'b1;
            end else begin
                req_pri = PRI_BR;
                req_tgt = br_tgt;
            end
        end
    end

    // Merge the new request with the pending one: equal or higher priority replaces it.
    always_comb begin
        take_new = (req_pri != PRI_NONE) && (req_pri >= pend_pri);
        eff_pri  = take_new ? req_pri : pend_pri;
        eff_tgt  = take_new ? req_tgt : pend_tgt;
    end

    // State, pc and pending-slot sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            pc         <= RESET_VECTOR;
            pend_pri   <= PRI_NONE;
            pend_tgt   <= '0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    misaligned <= 1'b0;
                    state      <= ST_RUN;
                end
                ST_RUN: begin
                    misaligned <= req_bad;
                    if (imem_ready) begin
                        pc       <= (eff_pri != PRI_NONE) ? eff_tgt : pc_plus4;
                        pend_pri <= PRI_NONE;
                        // A trap taken on this boundary overrides the halt request.
                        if (halt_req && (eff_pri != PRI_TRAP)) begin
                            state <= ST_HALT;
                        end
                    end else begin
                        pend_pri <= eff_pri;
                        pend_tgt <= eff_tgt;
                    end
                end
                ST_HALT: begin
                    misaligned <= 1'b0;
                    pend_pri   <= PRI_NONE;
                    if (trap) begin
                        pc    <= TRAP_VECTOR;
                        state <= ST_RUN;
                    end else if (resume) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    misaligned <= 1'b0;
                    pend_pri   <= PRI_NONE;
                    state      <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios pinned to literal values, then randomized traffic
// with a behavioural model checked every cycle at the falling edge.
// Inputs change only after the falling edge; reset is also pulsed asynchronously between edges.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src;
    logic [15:0] pc_target;
    logic        jalr;
    logic [15:0] jalr_base;
    logic [15:0] jalr_offset;
    logic        trap;
    logic        halt_req;
    logic        resume;
    logic        imem_ready;
    logic [15:0] pc;
    logic [15:0] pc_plus4;
    logic        pc_valid;
    logic        misaligned;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Model: mode 0=boot 1=run 2=halted; pending priority 0 means empty.
    int          m_mode;
    logic [15:0] m_pc;
    int          m_pend_pri;
    logic [15:0] m_pend_tgt;
    logic        m_mis;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .jalr        (jalr),
        .jalr_base   (jalr_base),
        .jalr_offset (jalr_offset),
        .trap        (trap),
        .halt_req    (halt_req),
        .resume      (resume),
        .imem_ready  (imem_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_valid    (pc_valid),
        .misaligned  (misaligned),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [15:0] e_p4;
        e_p4 = m_pc + 16'd4;
        chk("pc", {16'h0, pc}, {16'h0, m_pc});
        chk("pc_plus4", {16'h0, pc_plus4}, {16'h0, e_p4});
        chk("pc_valid", {31'h0, pc_valid}, {31'h0, (m_mode == 1)});
        chk("halted", {31'h0, halted}, {31'h0, (m_mode == 2)});
        chk("misaligned", {31'h0, misaligned}, {31'h0, m_mis});
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_pc       = 16'h0000;
        m_pend_pri = 0;
        m_pend_tgt = 16'h0000;
        m_mis      = 1'b0;
    endtask

    // Next model state from the current inputs, following the rules directly.
    task automatic model_step();
        int          npri;
        logic [15:0] ntgt;
        logic [15:0] t;
        logic        bad_tgt;
        int          epri;
        logic [15:0] etgt;
        npri    = 0;
        ntgt    = 16'h0;
        bad_tgt = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
            m_mis  = 1'b0;
        end else if (m_mode == 2) begin
            m_mis      = 1'b0;
            m_pend_pri = 0;
            if (trap) begin
                m_pc   = 16'h0010;
                m_mode = 1;
            end else if (resume) begin
                m_mode = 1;
            end
        end else begin
            if (trap) begin
                npri = 3;
                ntgt = 16'h0010;
            end else if (jalr) begin
                t = jalr_base + jalr_offset;
                t = t & 16'hFFFE;
                if (t % 4 != 0) bad_tgt = 1'b1;
                else begin npri = 2; ntgt = t; end
            end else if (pc_src) begin
                t = m_pc + pc_target;
                if (t % 4 != 0) bad_tgt = 1'b1;
                else begin npri = 1; ntgt = t; end
            end
            m_mis = bad_tgt;
            if (npri != 0 && npri >= m_pend_pri) begin
                epri = npri;
                etgt = ntgt;
            end else begin
                epri = m_pend_pri;
                etgt = m_pend_tgt;
            end
            if (imem_ready) begin
                m_pc       = (epri != 0) ? etgt : m_pc + 16'd4;
                m_pend_pri = 0;
                if (halt_req && epri != 3) m_mode = 2;
            end else begin
                m_pend_pri = epri;
                m_pend_tgt = etgt;
            end
        end
    endtask

    // One clock: model advances with the edge, outputs compared at the falling edge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        pc_src      = 1'b0;
        pc_target   = 16'h0;
        jalr        = 1'b0;
        jalr_base   = 16'h0;
        jalr_offset = 16'h0;
        trap        = 1'b0;
        halt_req    = 1'b0;
        resume      = 1'b0;
        imem_ready  = 1'b1;
    endtask

    // Reset asserted between edges: outputs must drop to reset values with no clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", {16'h0, pc}, 32'h0);
        chk("async_rst_valid", {31'h0, pc_valid}, 32'h0);
        chk("async_rst_halted", {31'h0, halted}, 32'h0);
        chk("async_rst_mis", {31'h0, misaligned}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        chk("boot_pc", {16'h0, pc}, 32'h0);
        chk("boot_valid", {31'h0, pc_valid}, 32'h0);

        // Sequential fetch from reset.
        step();
        chk("run_pc0", {16'h0, pc}, 32'h0);
        chk("run_valid", {31'h0, pc_valid}, 32'h1);
        step();
        chk("seq_pc4", {16'h0, pc}, 32'h4);
        step();
        chk("seq_pc8", {16'h0, pc}, 32'h8);

        // Branch with negative offset and wrap at top of address space.
        idle(); jalr = 1'b1; jalr_base = 16'h0020;
        step();
        chk("jalr_pc20", {16'h0, pc}, 32'h20);
        idle(); pc_src = 1'b1; pc_target = 16'hFFF8;
        step();
        chk("branch_back", {16'h0, pc}, 32'h18);
        idle(); jalr = 1'b1; jalr_base = 16'hFFFC;
        step();
        chk("jalr_top", {16'h0, pc}, 32'hFFFC);
        chk("plus4_wrap", {16'h0, pc_plus4}, 32'h0);
        idle();
        step();
        chk("seq_wrap", {16'h0, pc}, 32'h0);

        // Misaligned jalr is dropped; bit 0 masking makes 0x104 legal.
        idle(); jalr = 1'b1; jalr_base = 16'h0101; jalr_offset = 16'h0002;
        step();
        chk("mis_pulse", {31'h0, misaligned}, 32'h1);
        chk("mis_seq_pc", {16'h0, pc}, 32'h4);
        idle(); jalr = 1'b1; jalr_base = 16'h0101; jalr_offset = 16'h0003;
        step();
        chk("jalr_mask", {16'h0, pc}, 32'h104);
        chk("mis_clear", {31'h0, misaligned}, 32'h0);

        // Branch held pending through three stalled cycles.
        idle(); imem_ready = 1'b0; pc_src = 1'b1; pc_target = 16'hFF3C;
        step();
        idle(); imem_ready = 1'b0;
        step();
        step();
        chk("stall_hold", {16'h0, pc}, 32'h104);
        idle();
        step();
        chk("pending_apply", {16'h0, pc}, 32'h40);

        // Halt, frozen pc, trap out of halt, halt+trap together, resume.
        idle(); halt_req = 1'b1;
        step();
        chk("halt_enter", {31'h0, halted}, 32'h1);
        chk("halt_pc", {16'h0, pc}, 32'h44);
        idle(); jalr = 1'b1; jalr_base = 16'h0200; pc_src = 1'b1; pc_target = 16'h0100;
        step();
        chk("halt_frozen", {16'h0, pc}, 32'h44);
        idle(); trap = 1'b1;
        step();
        chk("halt_trap_pc", {16'h0, pc}, 32'h10);
        chk("halt_trap_valid", {31'h0, pc_valid}, 32'h1);
        idle(); trap = 1'b1; halt_req = 1'b1;
        step();
        chk("halt_trap_same", {16'h0, pc}, 32'h10);
        chk("halt_trap_run", {31'h0, halted}, 32'h0);
        idle(); halt_req = 1'b1;
        step();
        idle(); resume = 1'b1;
        step();
        chk("resume_pc", {16'h0, pc}, 32'h14);
        chk("resume_valid", {31'h0, pc_valid}, 32'h1);

        // Reset while a redirect is pending: its target must never be fetched.
        idle(); imem_ready = 1'b0; pc_src = 1'b1; pc_target = 16'h0100;
        step();
        async_reset();
        idle();
        step();
        chk("post_rst_pc0", {16'h0, pc}, 32'h0);
        step();
        chk("post_rst_pc4", {16'h0, pc}, 32'h4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            trap        = ($urandom_range(0, 15) == 0);
            jalr        = ($urandom_range(0, 7) == 0);
            pc_src      = ($urandom_range(0, 5) == 0);
            halt_req    = ($urandom_range(0, 19) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            imem_ready  = ($urandom_range(0, 9) < 7);
            jalr_base   = 16'($urandom);
            if ($urandom_range(0, 1) == 0) jalr_base = jalr_base & 16'hFFFC;
            jalr_offset = 16'($urandom_range(0, 64));
            if ($urandom_range(0, 2) != 0) jalr_offset = jalr_offset & 16'hFFFC;
            pc_target   = 16'($urandom);
            if ($urandom_range(0, 9) < 7) pc_target = pc_target & 16'hFFFC;
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 16, the width of every address port and internal address register.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, the first fetch address after reset.
REQ-003 The block SHALL have parameter TRAP_VECTOR, default 'h10, the redirect address for a trap.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port pc_src, input, 1 bit, branch taken; target is pc + pc_target.
REQ-007 The block SHALL have port pc_target, input, PC_WIDTH bits, the branch offset (two's complement).
REQ-008 The block SHALL have port jalr, input, 1 bit, register-indirect jump request.
REQ-009 The block SHALL have port jalr_base, input, PC_WIDTH bits, the jump base.
REQ-010 The block SHALL have port jalr_offset, input, PC_WIDTH bits, the jump offset.
REQ-011 The block SHALL have port trap, input, 1 bit, trap request; target is TRAP_VECTOR.
REQ-012 The block SHALL have port halt_req, input, 1 bit, enter HALTED at the next accepted boundary.
REQ-013 The block SHALL have port resume, input, 1 bit, leave HALTED.
REQ-014 The block SHALL have port imem_ready, input, 1 bit, instruction memory accepts the current pc this cycle.
REQ-015 The block SHALL have port pc, output, PC_WIDTH bits, the current fetch address.
REQ-016 The block SHALL have port pc_plus4, output, PC_WIDTH bits, combinational pc + 4 modulo 2^PC_WIDTH.
REQ-017 The block SHALL have port pc_valid, output, 1 bit, pc is a real fetch request.
REQ-018 The block SHALL have port misaligned, output, 1 bit, one-cycle pulse flagging a rejected redirect target.
REQ-019 The block SHALL have port halted, output, 1 bit, high while in state HALTED.

Function
REQ-020 The block SHALL implement states BOOT, RUN and HALTED, with the state register in the clk/rst domain.
REQ-021 BOOT SHALL last exactly one cycle, with pc_valid=0 and pc=RESET_VECTOR, then go to RUN unconditionally.
REQ-022 In RUN, pc_valid SHALL be 1; a fetch is accepted in any cycle with pc_valid=1 and imem_ready=1.
REQ-023 On an accepted fetch with no redirect, pc SHALL become pc + 4, wrapping modulo 2^PC_WIDTH.
REQ-024 Redirect priority SHALL be trap > jalr > pc_src; only the winner is used.
REQ-025 The jalr target SHALL be (jalr_base + jalr_offset) with bit 0 forced to 0.
REQ-026 The branch target SHALL be pc + pc_target; all address arithmetic SHALL be PC_WIDTH bits, with carries discarded.
REQ-027 If the winning jalr or branch target has bits [1:0] != 0 after jalr masking, the redirect SHALL be discarded, misaligned SHALL pulse for one cycle, and normal sequencing SHALL continue.
REQ-028 A redirect asserted while imem_ready=0 SHALL be captured in a one-entry pending register; pc SHALL hold.
REQ-029 The pending redirect SHALL be applied on the first cycle with imem_ready=1, and pc SHALL load the pending target.
REQ-030 A new redirect SHALL overwrite a lower-priority pending one and SHALL be ignored if its priority is lower; trap always overwrites.
REQ-031 A redirect SHALL take effect on the clock edge at which it is accepted: latency 1 cycle from request to new pc.
REQ-032 halt_req in RUN SHALL enter HALTED after the current accepted fetch, with pc advanced or redirected as normal; pc_valid=0 and pc held while HALTED.
REQ-033 In HALTED, a trap SHALL load TRAP_VECTOR and return to RUN in one cycle; resume SHALL return to RUN with pc unchanged; jalr and pc_src SHALL be ignored.
REQ-034 With halt_req and trap in the same cycle, the trap SHALL win, the state SHALL stay RUN, and pc SHALL equal TRAP_VECTOR.
REQ-035 The pending register SHALL clear when its redirect is applied, and on entry to HALTED.

Reset
REQ-036 rst=1 SHALL immediately set state=BOOT, pc=RESET_VECTOR, pc_valid=0, misaligned=0, halted=0, and clear the pending register, independent of clk.
REQ-037 Reset asserted mid-operation, including with a pending redirect or in HALTED, SHALL discard all in-flight requests.

Verification
REQ-038 Reset release with imem_ready=1 SHALL give pc=0 with pc_valid=0 for 1 cycle, then 0, 4, 8, ...
REQ-039 With pc=0x20 and pc_src=1, pc_target=0xFFF8 -> next pc=0x18; with pc=0xFFFC and no redirect -> next pc=0x0000.
REQ-040 With jalr=1, base=0x101, offset=0x2 -> misaligned pulse and pc+4; with base=0x101, offset=0x3 -> pc=0x104.
REQ-041 With imem_ready=0 for 3 cycles and pc_src asserted in cycle 1, target 0x40 -> pc held, then 0x40 on the first ready cycle.
REQ-042 halt_req, then trap while HALTED -> halted=1, pc frozen, then pc=0x10 with pc_valid=1 on the next cycle; halt_req together with trap -> pc=0x10 and halted=0.
REQ-043 rst pulsed between clock edges while a redirect is pending -> outputs reach reset values without a clock edge, and the pending target is never fetched.
